// File: rtl/memory_stage_if.sv
`default_nettype none
// ============================================================================
//  Module      : memory_stage_if
//  Description : Data-memory bus between the MEM pipeline stage (master) and
//                the external data memory (slave). Valid/ready handshake; the
//                request is held until the memory answers with ready.
//  Signals     : req   - request valid (master -> slave)
//                we    - 1 = store, 0 = load (master -> slave)
//                addr  - word-aligned byte address (master -> slave)
//                wdata - store data (master -> slave)
//                ready - request accepted/completed (slave -> master)
//                rdata - load data, valid with ready (slave -> master)
//  Revision    : 1.0 - initial release
// ============================================================================
interface memory_stage_if;
    logic        req;
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        ready;
    logic [31:0] rdata;

    modport master (
        output req,
        output we,
        output addr,
        output wdata,
        input  ready,
        input  rdata
    );

    modport slave (
        input  req,
        input  we,
        input  addr,
        input  wdata,
        output ready,
        output rdata
    );
endinterface
`default_nettype wire

// File: rtl/memory_stage.sv
`default_nettype none
// ============================================================================
//  Module      : memory_stage
//  Description : Pipeline MEM stage. Issues word loads/stores to the data
//                memory over a valid/ready bus, stalls the upstream pipeline
//                while an access is outstanding, aborts an access with a bus
//                error after TIMEOUT_CYCLES unanswered WAIT cycles, and owns
//                the MEM/WB pipeline register plus its forwarding value.
//  Ports       : i_clk, i_reset (async, active low)
//                i_ex_mem_*        - EX/MEM register contents
//                dmem              - data-memory bus (master side)
//                o_stall           - freeze PC, IF/ID, ID/EX, EX/MEM
//                o_misaligned      - pulse: memory op with addr[1:0] != 0
//                o_bus_error       - pulse: access timed out
//                o_mem_wb_*        - MEM/WB register contents
//                o_mem_wb_write_data - write-back / forwarding value
//  Revision    : 1.0 - initial release
// ============================================================================
module memory_stage #(
    parameter int TIMEOUT_CYCLES = 16,
    parameter int CNT_W          = 5
) (
    input  wire logic        i_clk,
    input  wire logic        i_reset,

    input  wire logic [31:0] i_ex_mem_alu_result,
    input  wire logic [31:0] i_ex_mem_write_data,
    input  wire logic [4:0]  i_ex_mem_rd,
    input  wire logic        i_ex_mem_reg_write,
    input  wire logic        i_ex_mem_mem_read,
    input  wire logic        i_ex_mem_mem_write,
    input  wire logic        i_ex_mem_mem_to_reg,

    memory_stage_if.master   dmem,

    output logic             o_stall,
    output logic             o_misaligned,
    output logic             o_bus_error,

    output logic [31:0]      o_mem_wb_read_data,
    output logic [31:0]      o_mem_wb_alu_result,
    output logic [4:0]       o_mem_wb_rd,
    output logic             o_mem_wb_reg_write,
    output logic             o_mem_wb_mem_to_reg,
    output logic [31:0]      o_mem_wb_write_data
);

    localparam logic [CNT_W-1:0] c_cnt_last = CNT_W'(TIMEOUT_CYCLES - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WAIT = 2'd1,
        S_RESP = 2'd2
    } state_t;

    state_t           r_state;
    state_t           w_state_next;
    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] w_cnt_next;
    logic [31:0]      r_cap;
    logic [31:0]      w_cap_next;

    logic             w_access;
    logic             w_aligned;
    logic             w_req;
    logic             w_stall;
    logic             w_misaligned;
    logic             w_bus_error;

    logic [31:0]      w_wb_read_data;
    logic [31:0]      w_wb_alu_result;
    logic [4:0]       w_wb_rd;
    logic             w_wb_reg_write;
    logic             w_wb_mem_to_reg;

    logic [31:0]      r_wb_read_data;
    logic [31:0]      r_wb_alu_result;
    logic [4:0]       r_wb_rd;
    logic             r_wb_reg_write;
    logic             r_wb_mem_to_reg;

    assign w_access  = i_ex_mem_mem_read | i_ex_mem_mem_write;
    assign w_aligned = (i_ex_mem_alu_result[1:0] == 2'b00);

    // ------------------------------------------------------------------
    // State, timeout counter, capture register and MEM/WB register
    // ------------------------------------------------------------------
    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            r_state         <= S_IDLE;
            r_cnt           <= '0;
            r_cap           <= '0;
            r_wb_read_data  <= '0;
            r_wb_alu_result <= '0;
            r_wb_rd         <= '0;
            r_wb_reg_write  <= 1'b0;
            r_wb_mem_to_reg <= 1'b0;
        end else begin
            r_state         <= w_state_next;
            r_cnt           <= w_cnt_next;
            r_cap           <= w_cap_next;
            r_wb_read_data  <= w_wb_read_data;
            r_wb_alu_result <= w_wb_alu_result;
            r_wb_rd         <= w_wb_rd;
            r_wb_reg_write  <= w_wb_reg_write;
            r_wb_mem_to_reg <= w_wb_mem_to_reg;
        end
    end

    // ------------------------------------------------------------------
    // Next state, handshake outputs and MEM/WB next contents
    // ------------------------------------------------------------------
    always_comb begin
        w_state_next    = r_state;
        w_cnt_next      = r_cnt;
        w_cap_next      = r_cap;
        w_req           = 1'b0;
        w_stall         = 1'b0;
        w_misaligned    = 1'b0;
        w_bus_error     = 1'b0;
        w_wb_read_data  = '0;
        w_wb_alu_result = i_ex_mem_alu_result;
        w_wb_rd         = i_ex_mem_rd;
        w_wb_reg_write  = i_ex_mem_reg_write;
        w_wb_mem_to_reg = i_ex_mem_mem_to_reg;

        case (r_state)
            S_IDLE: begin
                if (w_access) begin
                    if (!w_aligned) begin
                        // Instruction retires without touching memory or
                        // the register file.
                        w_misaligned   = 1'b1;
                        w_wb_reg_write = 1'b0;
                    end else begin
                        w_req           = 1'b1;
                        w_stall         = 1'b1;
                        w_wb_alu_result = '0;
                        w_wb_rd         = '0;
                        w_wb_reg_write  = 1'b0;
                        w_wb_mem_to_reg = 1'b0;
                        if (dmem.ready) begin
                            w_cap_next   = dmem.rdata;
                            w_state_next = S_RESP;
                        end else begin
                            w_cnt_next   = '0;
                            w_state_next = S_WAIT;
                        end
                    end
                end
            end

            S_WAIT: begin
                w_req           = 1'b1;
                w_stall         = 1'b1;
                w_wb_alu_result = '0;
                w_wb_rd         = '0;
                w_wb_reg_write  = 1'b0;
                w_wb_mem_to_reg = 1'b0;
                w_cnt_next      = r_cnt + 1'b1;
                // Ready takes priority over a coinciding timeout.
                if (dmem.ready) begin
                    w_cap_next   = dmem.rdata;
                    w_state_next = S_RESP;
                end else if (r_cnt == c_cnt_last) begin
                    w_bus_error  = 1'b1;
                    w_cap_next   = '0;
                    w_state_next = S_RESP;
                end
            end

            S_RESP: begin
                // Stores write back zero read data; loads the captured word.
                w_wb_read_data = i_ex_mem_mem_write ? 32'd0 : r_cap;
                w_state_next   = S_IDLE;
            end

            default: begin
                w_state_next = S_IDLE;
            end
        endcase
    end

    // Pulses and the request are masked while reset is held so that an
    // asynchronous reset silences the bus immediately, whatever the inputs.
    assign dmem.req     = w_req & i_reset;
    assign dmem.we      = i_ex_mem_mem_write;
    assign dmem.addr    = i_ex_mem_alu_result;
    assign dmem.wdata   = i_ex_mem_write_data;

    assign o_stall      = w_stall & i_reset;
    assign o_misaligned = w_misaligned & i_reset;
    assign o_bus_error  = w_bus_error & i_reset;

    assign o_mem_wb_read_data  = r_wb_read_data;
    assign o_mem_wb_alu_result = r_wb_alu_result;
    assign o_mem_wb_rd         = r_wb_rd;
    assign o_mem_wb_reg_write  = r_wb_reg_write;
    assign o_mem_wb_mem_to_reg = r_wb_mem_to_reg;
    assign o_mem_wb_write_data = r_wb_mem_to_reg ? r_wb_read_data : r_wb_alu_result;

endmodule
`default_nettype wire
